// File: rtl/udm_uart_pkg.sv
// Shared types and constants for the auto-baud UART receiver of the UDM debug path.
package udm_uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        MEASURE,
        START,
        DATA,
        STOP,
        BREAK
    } rx_state_t;

    // 0x55 sent LSB-first has falling edges at bit times 0,2,4,6,8: five edges span 8 bit periods.
    localparam logic [7:0]  SYNC_BYTE  = 8'h55;
    localparam int unsigned SYNC_EDGES = 5;
    localparam int unsigned SYNC_SHIFT = 3;

endpackage

// File: rtl/udm_uart_rx_autobaud_if.sv
// Received-byte stream from the UART front-end to the UDM command decoder (no backpressure).
interface udm_uart_rx_autobaud_if;

    logic [7:0] data_o;
    logic       valid_o;
    logic       frame_err_o;

    modport master (output data_o, valid_o, frame_err_o);
    modport slave  (input  data_o, valid_o, frame_err_o);

endinterface

// File: rtl/udm_rx_filter.sv
// 2-FF synchroniser plus glitch filter for the asynchronous rx pin; flags accepted falling edges.
module udm_rx_filter #(
    parameter int unsigned FILTER_LEN = 2
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic rx_i,
    output logic rxf_o,
    output logic fall_o
);

    localparam int unsigned FW = $clog2(FILTER_LEN + 1);

    logic [1:0]    sync;
    logic [FW-1:0] hold_cnt;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sync     <= '1;
            rxf_o    <= 1'b1;
            hold_cnt <= '0;
            fall_o   <= 1'b0;
        end else begin
            sync   <= {sync[0], rx_i};
            fall_o <= 1'b0;
            if (sync[1] == rxf_o) begin
                hold_cnt <= '0;
            end else if (hold_cnt == FW'(FILTER_LEN - 1)) begin
                // New level held for FILTER_LEN clocks: accept it.
                rxf_o    <= sync[1];
                hold_cnt <= '0;
                fall_o   <= ~sync[1];
            end else begin
                hold_cnt <= hold_cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/udm_uart_rx_autobaud.sv
// 8N1 UART receiver that learns its bit period from the 0x55 sync byte opening each debug session.
module udm_uart_rx_autobaud
    import udm_uart_pkg::*;
#(
    parameter int unsigned CNT_WIDTH  = 20,
    parameter int unsigned MIN_DIV    = 8,
    parameter int unsigned FILTER_LEN = 2
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     rx_i,
    input  logic                     resync_i,
    udm_uart_rx_autobaud_if.master   rx_if,
    output logic                     locked_o,
    output logic [CNT_WIDTH-1:0]     divider_o
);

    rx_state_t            state;
    logic [CNT_WIDTH-1:0] cnt;
    logic [2:0]           edges;
    logic [2:0]           bit_idx;
    logic [7:0]           shift;
    logic [7:0]           data_q;
    logic                 valid_q;
    logic                 ferr_q;
    logic                 rxf;
    logic                 fall;

    logic [CNT_WIDTH-1:0] measured;
    logic                 half_end;
    logic                 bit_end;

    udm_rx_filter #(
        .FILTER_LEN (FILTER_LEN)
    ) u_filter (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .rx_i   (rx_i),
        .rxf_o  (rxf),
        .fall_o (fall)
    );

    assign measured = cnt >> SYNC_SHIFT;
    assign half_end = (cnt == (divider_o >> 1) - 1'b1);
    assign bit_end  = (cnt == divider_o - 1'b1);

    assign rx_if.data_o      = data_q;
    assign rx_if.valid_o     = valid_q;
    assign rx_if.frame_err_o = ferr_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state     <= IDLE;
            cnt       <= '0;
            edges     <= '0;
            bit_idx   <= '0;
            shift     <= '0;
            data_q    <= '0;
            valid_q   <= 1'b0;
            ferr_q    <= 1'b0;
            locked_o  <= 1'b0;
            divider_o <= '0;
        end else begin
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
            if (resync_i) begin
                locked_o <= 1'b0;
                state    <= BREAK;
            end else begin
                case (state)
                    IDLE: begin
                        if (fall) begin
                            // MEASURE counts the edge clock itself, so cnt tracks clocks since the first edge.
                            cnt     <= locked_o ? '0 : CNT_WIDTH'(1);
                            edges   <= 3'd1;
                            bit_idx <= '0;
                            state   <= locked_o ? START : MEASURE;
                        end
                    end
                    MEASURE: begin
                        if (cnt == '1) begin
                            state <= BREAK;
                        end else begin
                            cnt <= cnt + 1'b1;
                            if (fall) begin
                                edges <= edges + 1'b1;
                                if (edges == 3'(SYNC_EDGES - 1)) begin
                                    if (measured >= CNT_WIDTH'(MIN_DIV)) begin
                                        divider_o <= measured;
                                        locked_o  <= 1'b1;
                                    end
                                    state <= BREAK;
                                end
                            end
                        end
                    end
                    START: begin
                        if (half_end) begin
                            cnt     <= '0;
                            bit_idx <= '0;
                            state   <= rxf ? IDLE : DATA;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                    DATA: begin
                        if (bit_end) begin
                            cnt     <= '0;
                            shift   <= {rxf, shift[7:1]};
                            bit_idx <= bit_idx + 1'b1;
                            if (bit_idx == 3'd7) begin
                                state <= STOP;
                            end
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                    STOP: begin
                        if (bit_end) begin
                            cnt <= '0;
                            if (rxf) begin
                                data_q  <= shift;
                                valid_q <= 1'b1;
                                state   <= IDLE;
                            end else begin
                                ferr_q <= 1'b1;
                                state  <= BREAK;
                            end
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                    BREAK: begin
                        if (rxf) begin
                            state <= IDLE;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule
